// File: rtl/fir_pkg.sv
// fir_pkg -- shared types and sizing helpers for the TDM FIR filter.
//   fir_state_e : IDLE / MAC / HOLD controller states
//   acc_width() : accumulator width for a given sample/coef width and tap count
//   cnt_width() : counter width able to index 0..n-1 (at least 1 bit)
//   DEF_DW, DEF_CW, DEF_SHIFT : default sample width, coef width, output shift
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        HOLD = 2'd2
    } fir_state_e;

    localparam int DEF_DW    = 24;
    localparam int DEF_CW    = 12;
    localparam int DEF_SHIFT = 11;

    // Sum of n products of dw x cw signed operands never overflows this width.
    function automatic int acc_width(input int dw, input int cw, input int n);
        return dw + cw + $clog2(n);
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_coef_ram.sv
// fir_coef_ram -- N x CW coefficient register file.
//   clk, rst_n : clock, async active-low reset (clears all entries)
//   we, waddr, wdata : single write port
//   raddr, rdata     : combinational read port (out-of-range address reads 0)
module fir_coef_ram #(
    parameter int N      = 31,
    parameter int CW     = 12,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [CW-1:0]     wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [CW-1:0]     rdata
);

    logic [N-1:0][CW-1:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = ({1'b0, raddr} < (ADDR_W+1)'(N)) ? mem[raddr] : '0;

endmodule

// File: rtl/fir_tdm_filter.sv
// fir_tdm_filter -- multi-channel FIR filter sharing one multiplier in time.
// A frame (one sample per channel) is accepted in IDLE, then CH*N MAC cycles
// walk taps 0..N-1 of channel 0, then channel 1, ...; the finished frame is
// held on audio_out with out_valid until out_ready.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : input frame handshake, audio_in[c*DW +: DW] = channel c
//   out_valid/out_ready   : output frame handshake, audio_out same packing
//   coef_we/addr/wdata    : coefficient write (honoured only in IDLE, addr < N)
//   coef_err              : one-cycle pulse when a coefficient write is dropped
// Build option: FIR_SATURATE_EN clamps results to the DW-bit signed range;
// without it results wrap to the low DW bits.
module fir_tdm_filter
    import fir_pkg::*;
#(
    parameter int N     = 31,
    parameter int CH    = 2,
    parameter int DW    = DEF_DW,
    parameter int CW    = DEF_CW,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*DW-1:0]     audio_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*DW-1:0]     audio_out,
    input  logic                 coef_we,
    input  logic [$clog2(N)-1:0] coef_addr,
    input  logic [CW-1:0]        coef_wdata,
    output logic                 coef_err
);

    localparam int AW  = acc_width(DW, CW, N);
    localparam int TW  = $clog2(N);
    localparam int CHW = cnt_width(CH);
    localparam int PW  = DW + CW;

    fir_state_e state, state_nxt;

    logic                        started;
    logic [CH-1:0][N-1:0][DW-1:0] dly;
    logic [TW-1:0]               tap_cnt;
    logic [CHW-1:0]              ch_cnt;
    logic signed [AW-1:0]        acc;
    logic [CH-1:0][DW-1:0]       res;

    logic                        accept, addr_ok, wr_en;
    logic                        tap_last, mac_last;
    logic [TW-1:0]               ram_raddr;
    logic [CW-1:0]               ram_rdata;

    // Old coefficient captured when a write lands on the same edge as a frame
    // accept; the frame in flight keeps using it while the RAM holds the new one.
    logic                        ovr_vld;
    logic [TW-1:0]               ovr_addr;
    logic [CW-1:0]               ovr_data;

    logic signed [DW-1:0]        mul_a;
    logic signed [CW-1:0]        mul_b;
    logic signed [PW-1:0]        prod;
    logic signed [AW-1:0]        acc_base, acc_nxt, shifted;
    logic [DW-1:0]               result;

    assign in_ready  = started && (state == IDLE);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign addr_ok   = ({1'b0, coef_addr} < (TW+1)'(N));
    assign wr_en     = coef_we && (state == IDLE) && addr_ok;
    assign tap_last  = (tap_cnt == TW'(N - 1));
    assign mac_last  = tap_last && (ch_cnt == CHW'(CH - 1));
    // In IDLE the read port looks at the write address so the old value can be
    // saved; during MAC it follows the tap counter.
    assign ram_raddr = (state == IDLE) ? coef_addr : tap_cnt;

    fir_coef_ram #(
        .N      (N),
        .CW     (CW),
        .ADDR_W (TW)
    ) u_coef_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (coef_addr),
        .wdata (coef_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // ---------------- controller ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = MAC;
            MAC:     if (mac_last)  state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- shared MAC datapath ----------------
    always_comb begin
        mul_a    = dly[ch_cnt][tap_cnt];
        mul_b    = (ovr_vld && (ovr_addr == tap_cnt)) ? ovr_data : ram_rdata;
        prod     = PW'(mul_a) * PW'(mul_b);
        // Tap 0 starts a fresh pass for the channel.
        acc_base = (tap_cnt == '0) ? '0 : acc;
        acc_nxt  = acc_base + AW'(prod);
        shifted  = acc_nxt >>> SHIFT;
`ifdef FIR_SATURATE_EN
        // Fits in DW bits only if every bit above the DW-1 sign bit matches it.
        if (shifted[AW-1:DW-1] == '0 || shifted[AW-1:DW-1] == '1)
            result = shifted[DW-1:0];
        else if (shifted[AW-1])
            result = {1'b1, {(DW-1){1'b0}}};
        else
            result = {1'b0, {(DW-1){1'b1}}};
`else
        result = shifted[DW-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started   <= 1'b0;
            dly       <= '0;
            tap_cnt   <= '0;
            ch_cnt    <= '0;
            acc       <= '0;
            res       <= '0;
            audio_out <= '0;
            coef_err  <= 1'b0;
            ovr_vld   <= 1'b0;
            ovr_addr  <= '0;
            ovr_data  <= '0;
        end else begin
            started  <= 1'b1;
            coef_err <= coef_we && !wr_en;

            if (accept) begin
                for (int c = 0; c < CH; c++)
                    dly[c] <= {dly[c][N-2:0], audio_in[c*DW +: DW]};
                tap_cnt  <= '0;
                ch_cnt   <= '0;
                ovr_vld  <= wr_en;
                ovr_addr <= coef_addr;
                ovr_data <= ram_rdata;
            end

            if (state == MAC) begin
                acc <= acc_nxt;
                if (tap_last) begin
                    res[ch_cnt] <= result;
                    tap_cnt     <= '0;
                    ch_cnt      <= ch_cnt + 1'b1;
                end else begin
                    tap_cnt <= tap_cnt + 1'b1;
                end
                // Publish the whole frame at once; the last channel comes
                // straight from this cycle's result.
                if (mac_last) begin
                    ovr_vld <= 1'b0;
                    for (int c = 0; c < CH; c++)
                        audio_out[c*DW +: DW] <= (CHW'(c) == ch_cnt) ? result : res[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_tdm_filter.sv
module tb_fir_tdm_filter;

    localparam int N = 8, CH = 2, DW = 24, CW = 12, SHIFT = 0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [47:0]   audio_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [47:0]   audio_out;
    logic          coef_we = 1'b0;
    logic [2:0]    coef_addr = '0;
    logic [11:0]   coef_wdata = '0;
    logic          coef_err;

    always #5 clk = ~clk;

    fir_tdm_filter #(.N(N), .CH(CH), .DW(DW), .CW(CW), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .audio_in(audio_in),
        .out_valid(out_valid), .out_ready(out_ready), .audio_out(audio_out),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .coef_err(coef_err)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: coefficient array plus per-channel sample history.
    int          m_coef [N];
    int          m_hist [CH][N];
    logic [23:0] m_exp0, m_exp1;

    typedef struct {
        logic [23:0] s0, s1, e0, e1;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] shape(input longint s);
        logic [63:0] v;
`ifdef FIR_SATURATE_EN
        if (s > 64'sd8388607)  return 24'h7FFFFF;
        if (s < -64'sd8388608) return 24'h800000;
`endif
        v = s;
        return v[23:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_coef[k] = 0;
            for (int c = 0; c < CH; c++) m_hist[c][k] = 0;
        end
    endtask

    task automatic model_accept(input logic [23:0] s0, input logic [23:0] s1);
        longint sum [CH];
        for (int c = 0; c < CH; c++)
            for (int k = N - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
        m_hist[0][0] = int'(signed'(s0));
        m_hist[1][0] = int'(signed'(s1));
        for (int c = 0; c < CH; c++) begin
            sum[c] = 0;
            for (int k = 0; k < N; k++)
                sum[c] += longint'(m_coef[k]) * longint'(m_hist[c][k]);
        end
        m_exp0 = shape(sum[0] >>> SHIFT);
        m_exp1 = shape(sum[1] >>> SHIFT);
    endtask

    // All tasks start and end just after a falling edge.
    task automatic write_coef(input int a, input int v);
        logic [11:0] wv;
        logic [2:0]  wa;
        wv = 12'(v);
        wa = 3'(a);
        coef_we = 1'b1; coef_addr = wa; coef_wdata = wv;
        @(negedge clk);
        coef_we = 1'b0;
        check("coef_err_idle", coef_err, 0);
        m_coef[a] = v;
    endtask

    task automatic start_frame(input logic [23:0] s0, input logic [23:0] s1,
                               input bit wr, input int wa, input int wd);
        int w = 0;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        check("accept_ready", in_ready, 1);
        in_valid = 1'b1;
        audio_in = {s1, s0};
        if (wr) begin
            coef_we = 1'b1; coef_addr = 3'(wa); coef_wdata = 12'(wd);
        end
        model_accept(s0, s1);          // frame sees the pre-write coefficients
        if (wr) m_coef[wa] = wd;
        @(negedge clk);
        in_valid = 1'b0;
        coef_we  = 1'b0;
    endtask

    // lat0 = cycles already elapsed since the accept cycle.
    task automatic finish_frame(input int lat0, input int bp,
                                output logic [23:0] g0, output logic [23:0] g1, output int lat);
        logic [47:0] held;
        lat = lat0;
        while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
        g0 = audio_out[23:0];
        g1 = audio_out[47:24];
        held = audio_out;
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check("bp_stable", audio_out, held);
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] g0, g1, s0, s1;
        int          lat, seen;

        for (int i = 0; i < 8; i++)
            tbl[i] = '{(i == 0) ? 24'd1 : 24'd0, 24'd0, 24'(i + 1), 24'd0};
        model_reset();

        // Reset state
        #1;
        check("rst_audio_out", audio_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_coef_err", coef_err, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);

        // Impulse response, coefficients 1..8
        for (int k = 0; k < N; k++) write_coef(k, k + 1);
        for (int i = 0; i < 8; i++) begin
            start_frame(tbl[i].s0, tbl[i].s1, 0, 0, 0);
            finish_frame(1, 0, g0, g1, lat);
            check("imp_ch0", g0, tbl[i].e0);
            check("imp_ch1", g1, tbl[i].e1);
            check("imp_latency", lat, 17);
        end

        // Backpressure: 10 cycles of out_ready=0 with in_valid pending
        start_frame(24'd0, 24'd0, 0, 0, 0);
        finish_frame(1, 10, g0, g1, lat);
        check("bp_ch0", g0, m_exp0);

        // Write attempted during MAC
        start_frame(24'd0, 24'd0, 0, 0, 0);
        @(negedge clk); @(negedge clk);
        check("busy_in_ready", in_ready, 0);
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 12'h055;
        @(negedge clk);
        coef_we = 1'b0;
        check("busy_err_pulse", coef_err, 1);
        @(negedge clk);
        check("busy_err_once", coef_err, 0);
        finish_frame(5, 0, g0, g1, lat);
        check("busy_latency", lat, 17);
        start_frame(24'd1, 24'd0, 0, 0, 0);
        finish_frame(1, 0, g0, g1, lat);
        check("busy_coef_kept", g0, 24'd1);

        // Random frames and coefficient updates against the model
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) == 0)
                write_coef($urandom_range(0, N - 1), int'($urandom_range(0, 4095)) - 2048);
            s0 = 24'($urandom());
            s1 = 24'($urandom());
            start_frame(s0, s1, 0, 0, 0);
            finish_frame(1, 0, g0, g1, lat);
            check("rand_ch0", g0, m_exp0);
            check("rand_ch1", g1, m_exp1);
        end

        // Large positive sum: clamps or wraps depending on the build
        for (int k = 0; k < N; k++) write_coef(k, 2047);
        for (int i = 0; i < 8; i++) begin
            start_frame(24'h7FFFFF, 24'h7FFFFF, 0, 0, 0);
            finish_frame(1, 0, g0, g1, lat);
            check("sat_model_ch0", g0, m_exp0);
            check("sat_model_ch1", g1, m_exp1);
        end
`ifdef FIR_SATURATE_EN
        check("sat_final", g0, 24'h7FFFFF);
`else
        check("wrap_final", g0, 24'hFFC008);
`endif

        // Reset during MAC cycle 5
        start_frame(24'h000123, 24'h000456, 0, 0, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_audio_out", audio_out, 0);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 0);
        check("mrst_coef_err", coef_err, 0);
        model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_ready", in_ready, 1);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mrst_no_valid", seen, 0);
        start_frame(24'd0, 24'd0, 0, 0, 0);
        finish_frame(1, 0, g0, g1, lat);
        check("mrst_zero_frame", {g1, g0}, 48'd0);

        // Same-edge write at address 0 (old coef 1, new coef 50)
        for (int k = 0; k < N; k++) write_coef(k, k + 1);
        start_frame(24'd5, 24'd3, 1, 0, 50);
        finish_frame(1, 0, g0, g1, lat);
        check("same_edge_old_ch0", g0, 24'd5);
        check("same_edge_old_ch1", g1, 24'd3);
        start_frame(24'd1, 24'd0, 0, 0, 0);
        finish_frame(1, 0, g0, g1, lat);
        check("same_edge_new_ch0", g0, 24'd60);
        check("same_edge_new_ch1", g1, 24'd6);
        check("same_edge_model", {g1, g0}, {m_exp1, m_exp0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fir_tdm_filter.md
FIR_TDM_FILTER -- requirements
Module: fir_tdm_filter

Interface
REQ-001 SHALL have parameter N, default 31: tap count, range 2..64.
REQ-002 SHALL have parameter CH, default 2: audio channels, range 1..8.
REQ-003 SHALL have parameter DW, default 24: sample width, signed.
REQ-004 SHALL have parameter CW, default 12: coefficient width, signed.
REQ-005 SHALL have parameter SHIFT, default 11: arithmetic right shift applied to the accumulator before output.
REQ-006 SHALL have ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input frame valid.
- in_ready  out  1  block can accept a frame.
- audio_in  in  CH*DW  input frame; channel c occupies bits [c*DW +: DW].
- out_valid  out  1  output frame valid.
- out_ready  in  1  downstream accepts the frame.
- audio_out  out  CH*DW  output frame; same packing as audio_in.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(N)  tap index.
- coef_wdata  in  CW  coefficient value, signed.
- coef_err  out  1  one-cycle pulse: write was dropped.

Function
REQ-007 SHALL implement three FSM states: IDLE, MAC, HOLD.
REQ-008 in_ready SHALL be 1 only in IDLE.
REQ-009 The input handshake SHALL complete when in_valid and in_ready are both 1. On that edge:
- each channel delay line shifts by one tap; the new sample enters tap 0;
- the FSM enters MAC.
REQ-010 MAC SHALL use one shared signed multiplier for exactly CH*N cycles, iterating taps 0..N-1 of channel 0, then channel 1, and so on.
REQ-011 Each channel's accumulator SHALL be signed, DW+CW+clog2(N) bits wide, and cleared at the start of that channel's pass.
REQ-012 Each channel result SHALL be acc >>> SHIFT, truncated toward negative infinity, then reduced to DW bits per REQ-022/REQ-023.
REQ-013 After the last MAC cycle, the FSM SHALL enter HOLD with the completed frame registered on audio_out and out_valid=1.
- Latency: out_valid rises CH*N+1 cycles after the accept edge.
REQ-014 In HOLD, audio_out and out_valid SHALL stay stable until out_ready=1; on that edge the FSM returns to IDLE and out_valid falls.
- Back-to-back throughput: one frame per CH*N+2 cycles.
REQ-015 audio_out SHALL retain its last value outside HOLD.
REQ-016 coef_we while in IDLE SHALL write coef_wdata into coef_addr, effective for the next frame.
REQ-017 coef_we in MAC or HOLD SHALL be dropped and pulse coef_err for one cycle.
REQ-018 If coef_addr >= N, coef_we SHALL be dropped and pulse coef_err.
REQ-019 If in_valid and coef_we arrive on the same IDLE edge, the write SHALL be applied and the frame SHALL use the old coefficient at that address.

Reset
REQ-020 While rst_n=0, the block SHALL force:
- FSM to IDLE;
- all delay lines, accumulators and coefficients to 0;
- audio_out=0, out_valid=0, coef_err=0, in_ready=0.
in_ready SHALL go to 1 on the first clk edge after rst_n deasserts.
REQ-021 A reset asserted mid-MAC or mid-HOLD SHALL discard the frame in progress; no out_valid SHALL follow.

Configuration
REQ-022 With FIR_SATURATE_EN defined, out-of-range results SHALL clamp to the DW-bit signed range [-2^(DW-1), 2^(DW-1)-1].
REQ-023 Without FIR_SATURATE_EN, results SHALL keep the low DW bits (two's-complement wrap).

Structure
REQ-024 Package fir_pkg SHALL hold:
- the FSM state enum;
- accumulator-width and counter-width functions;
- default DW, CW and SHIFT constants.
REQ-025 Sub-module fir_coef_ram SHALL hold the N x CW coefficient register file, with one write port and one combinational read port.

Verification
REQ-026 Bench SHALL use N=8, CH=2 and SHIFT=0, and SHALL cover:
- Impulse: coefficients 1..8; frame ch0=1, ch1=0, then seven zero frames. Required: ch0 outputs 1,2,...,8; ch1 all 0; each out_valid exactly 17 cycles after its accept.
- Backpressure: hold out_ready=0 for 10 cycles. Required: audio_out stable, in_ready=0 throughout, no second accept.
- Busy write: coef_we during MAC. Required: coef_err pulses once; coefficient unchanged on the next impulse.
- Saturation: all coefficients 2047; constant input 0x7FFFFF. With FIR_SATURATE_EN the output is 0x7FFFFF; without it the output is the low 24 bits of the sum.
- Mid-MAC reset: assert rst_n=0 at MAC cycle 5. Required: all outputs 0; no out_valid afterwards; after release, a zero frame yields 0.
- Same-edge write: same-edge write plus frame at address 0. Required: the frame uses the old coefficient; the following frame uses the new one.
